// File: rtl/hv_mem_pkg.sv
// Shared types and constants for the multi-port HV memory emulator.
// The optional HV_MEM_STALL_EN build uses the LFSR constants below.
package hv_mem_pkg;

  localparam int unsigned HV_DATA_WIDTH_DEF    = 32;
  localparam int unsigned HV_ADDRESS_WIDTH_DEF = 21;

  localparam int unsigned MAX_PORTS      = 8;
  localparam int unsigned MAX_RD_LATENCY = 16;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [HV_DATA_WIDTH_DEF-1:0]    hv_word_t;
  typedef logic [HV_ADDRESS_WIDTH_DEF-1:0] hv_addr_t;

endpackage

// File: rtl/hv_mem_lfsr.sv
// 16-bit Fibonacci LFSR producing a pseudo-random stall strobe for one port.
// Only instantiated when HV_MEM_STALL_EN is defined.
module hv_mem_lfsr
  import hv_mem_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic clk,
  input  logic reset_n,
  output logic stall_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/hv_mem_emulator.sv
// Multi-port HV memory model: shared array, per-port fixed-latency read pipelines.
// Define HV_MEM_STALL_EN to add LFSR-driven backpressure on ready.
module hv_mem_emulator
  import hv_mem_pkg::*;
#(
  parameter int unsigned HV_DATA_WIDTH    = HV_DATA_WIDTH_DEF,
  parameter int unsigned HV_ADDRESS_WIDTH = HV_ADDRESS_WIDTH_DEF,
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned RD_LATENCY       = 1,
  parameter int unsigned CLEAR_ON_RESET   = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_PORTS-1:0]                         req,
  input  logic [NUM_PORTS-1:0]                         we_n,
  input  logic [NUM_PORTS-1:0][HV_ADDRESS_WIDTH-1:0]   address,
  input  logic [NUM_PORTS-1:0][HV_DATA_WIDTH-1:0]      data_i,
  output logic [NUM_PORTS-1:0]                         ready,
  output logic [NUM_PORTS-1:0]                         rvalid,
  output logic [NUM_PORTS-1:0][HV_DATA_WIDTH-1:0]      data_o
);

  localparam int unsigned Depth = 2 ** HV_ADDRESS_WIDTH;
  localparam int unsigned RdLat = (RD_LATENCY < 1) ? 1 :
                                  (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
  localparam int unsigned NumWr = (NUM_PORTS > MAX_PORTS) ? MAX_PORTS : NUM_PORTS;

  logic                     rdy_en_q;
  logic [NUM_PORTS-1:0]     stall;
  logic [NUM_PORTS-1:0]     rd_acc;
  logic [NUM_PORTS-1:0]     wr_acc;
  logic [HV_DATA_WIDTH-1:0] mem_q [Depth];

  // ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

`ifdef HV_MEM_STALL_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stall
    hv_mem_lfsr #(
      .SEED(LFSR_SEED ^ 16'(p))
    ) u_lfsr (
      .clk    (clk),
      .reset_n(reset_n),
      .stall_o(stall[p])
    );
  end
`else
  assign stall = '0;
`endif

  always_comb begin
    ready  = {NUM_PORTS{rdy_en_q}} & ~stall;
    rd_acc = req & ready & we_n;
    wr_acc = req & ready & ~we_n;
  end

  // Ascending port order makes the highest-index writer win an address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET != 0) begin
        mem_q <= '{default: '0};
      end
    end else begin
      for (int unsigned p = 0; p < NumWr; p++) begin
        if (wr_acc[p]) begin
          mem_q[address[p]] <= data_i[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    logic [RdLat-1:0]         vld_q, vld_d;
    logic [HV_DATA_WIDTH-1:0] dat_q [RdLat];
    logic [HV_DATA_WIDTH-1:0] dat_d [RdLat];

    // Stage 0 samples the array before this edge's writes land (read-first).
    always_comb begin
      vld_d[0] = rd_acc[p];
      dat_d[0] = rd_acc[p] ? mem_q[address[p]] : '0;
      for (int i = 1; i < RdLat; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        dat_q <= '{default: '0};
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign rvalid[p] = vld_q[RdLat-1];
    assign data_o[p] = dat_q[RdLat-1];
  end

endmodule
